// File: rtl/lu_pkg.sv
// Shared definitions for the logic unit and its bit-serial sequencer:
// opcode constants, sequencer state encoding and default datapath width.
package lu_pkg;

   localparam int LU_WIDTH_DEFAULT = 8;

   localparam logic [2:0] LUOP_AND  = 3'd0;
   localparam logic [2:0] LUOP_OR   = 3'd1;
   localparam logic [2:0] LUOP_XOR  = 3'd2;
   localparam logic [2:0] LUOP_NAND = 3'd3;
   localparam logic [2:0] LUOP_NOR  = 3'd4;
   localparam logic [2:0] LUOP_XNOR = 3'd5;
   localparam logic [2:0] LUOP_PASA = 3'd6;
   localparam logic [2:0] LUOP_NOTA = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } lu_state_t;

endpackage

// File: rtl/lu.sv
// Single-bit combinational logic unit; one opcode selects one of eight
// two-input boolean functions of a and b.
module lu
   import lu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [2:0] luop,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      case (luop)
         LUOP_AND:  y = a & b;
         LUOP_OR:   y = a | b;
         LUOP_XOR:  y = a ^ b;
         LUOP_NAND: y = ~(a & b);
         LUOP_NOR:  y = ~(a | b);
         LUOP_XNOR: y = ~(a ^ b);
         LUOP_PASA: y = a;
         LUOP_NOTA: y = ~a;
         default:   y = 1'b0;
      endcase
   end

endmodule

// File: rtl/lu_sequencer.sv
// Bit-serial sequencer: feeds operands LSB-first through one LU bit and
// assembles the result by shifting LU output in from the MSB side.
module lu_sequencer
   import lu_pkg::*;
#(
   parameter int WIDTH = LU_WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       luop,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   lu_state_t        state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] result_reg;
   logic [2:0]       luop_reg;
   logic [CW-1:0]    cnt_reg;
   logic             accept;
   logic             lu_y;

   lu u_lu (
      .a    (a_sh_reg[0]),
      .b    (b_sh_reg[0]),
      .luop (luop_reg),
      .y    (lu_y)
   );

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // The last RUN edge shifts in the MSB, so result is complete on entry to DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         luop_reg   <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
      end else if (accept) begin
         a_sh_reg   <= op_a;
         b_sh_reg   <= op_b;
         luop_reg   <= luop;
         cnt_reg    <= '0;
         result_reg <= '0;
      end else if (state_reg == ST_RUN) begin
         a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
         b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
         result_reg <= {lu_y, result_reg[WIDTH-1:1]};
         cnt_reg    <= cnt_reg + CW'(1);
      end
   end

   assign busy   = (state_reg == ST_RUN);
   assign done   = (state_reg == ST_DONE);
   assign result = result_reg;

endmodule

// File: tb/tb_lu_sequencer.sv
// Directed self-checking bench for lu_sequencer at WIDTH=8.
`timescale 1ns/1ps
module tb_lu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [2:0] luop;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int checks;
   int failures;

   lu_sequencer #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .luop   (luop),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue a one-cycle start; returns #1 after the edge that samples it.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      op_a  = a;
      op_b  = b;
      luop  = op;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges are numbered relative to the start edge; lat = -1 if done never seen.
   task automatic wait_done(input int from_edge, output int lat);
      lat = -1;
      for (int n = from_edge; n <= 24; n++) begin
         if (lat < 0) begin
            @(posedge clk);
            #1;
            if (done) lat = n;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      op_a  = 8'hFF;
      op_b  = 8'hFF;
      luop  = 3'd1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b result=%h, required busy=0 done=0 result=00",
                  busy, done, result);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || result !== 8'h00) begin
         failures++;
         $display("FAIL reset_idle: busy=%b result=%h, required busy=0 result=00", busy, result);
      end
   endtask

   task automatic test_all_ops();
      logic [7:0] exp_tab [8];
      int lat;
      exp_tab[0] = 8'hC0; // AND
      exp_tab[1] = 8'hFC; // OR
      exp_tab[2] = 8'h3C; // XOR
      exp_tab[3] = 8'h3F; // NAND
      exp_tab[4] = 8'h03; // NOR
      exp_tab[5] = 8'hC3; // XNOR
      exp_tab[6] = 8'hF0; // pass A
      exp_tab[7] = 8'h0F; // not A
      for (int op = 0; op < 8; op++) begin
         start_op(8'hF0, 8'hCC, 3'(op));
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL op%0d_busy: busy=%b, required 1", op, busy);
         end
         wait_done(1, lat);
         checks++;
         if (lat != 8) begin
            failures++;
            $display("FAIL op%0d_latency: done after edge %0d, required 8", op, lat);
         end
         checks++;
         if (result !== exp_tab[op]) begin
            failures++;
            $display("FAIL op%0d_result: result=%h, required %h", op, result, exp_tab[op]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== exp_tab[op]) begin
            failures++;
            $display("FAIL op%0d_after: done=%b busy=%b result=%h, required 0 0 %h",
                     op, done, busy, result, exp_tab[op]);
         end
         $display("op %0d: F0 op CC -> %h latency %0d", op, result, lat);
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      start_op(8'hF0, 8'hCC, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      op_a  = 8'h00;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(4, lat);
      checks++;
      if (lat != 8) begin
         failures++;
         $display("FAIL restart_latency: done after edge %0d, required 8", lat);
      end
      checks++;
      if (result !== 8'hC0) begin
         failures++;
         $display("FAIL restart_result: result=%h, required c0", result);
      end
      $display("start during run: result %h", result);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_input_change();
      int lat;
      start_op(8'hA5, 8'h3C, 3'd2);
      lat = -1;
      for (int n = 1; n <= 24; n++) begin
         if (lat < 0) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            luop = 3'($urandom);
            @(posedge clk);
            #1;
            if (done) lat = n;
         end
      end
      checks++;
      if (lat != 8 || result !== 8'h99) begin
         failures++;
         $display("FAIL input_change: latency=%0d result=%h, required 8 99", lat, result);
      end
      $display("inputs toggled during run: result %h", result);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bit saw_done;
      start_op(8'hF0, 8'hCC, 3'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
         failures++;
         $display("FAIL midrun_reset: busy=%b done=%b result=%h, required 0 0 00",
                  busy, done, result);
      end
      saw_done = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL midrun_abort: activity seen after reset=1, required 0");
      end
      start_op(8'h0F, 8'h33, 3'd3);
      wait_done(1, lat);
      checks++;
      if (lat != 8 || result !== 8'hFC) begin
         failures++;
         $display("FAIL after_reset_op: latency=%0d result=%h, required 8 fc", lat, result);
      end
      $display("reset mid run, then NAND 0F 33 -> %h", result);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int last_done;
      int ndone;
      int busy_cnt;
      op_a  = 8'hF0;
      op_b  = 8'hCC;
      luop  = 3'd4;
      start = 1'b1;
      last_done = -1;
      ndone     = 0;
      busy_cnt  = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            ndone++;
            checks++;
            if (busy !== 1'b0 || result !== 8'h03 || busy_cnt != 8) begin
               failures++;
               $display("FAIL b2b_done%0d: busy=%b result=%h busy_cycles=%0d, required 0 03 8",
                        ndone, busy, result, busy_cnt);
            end
            if (last_done >= 0) begin
               checks++;
               if (c - last_done != 10) begin
                  failures++;
                  $display("FAIL b2b_period: %0d cycles between done, required 10", c - last_done);
               end
            end
            $display("back-to-back done at cycle %0d result %h", c, result);
            last_done = c;
            busy_cnt  = 0;
         end
      end
      checks++;
      if (ndone != 4) begin
         failures++;
         $display("FAIL b2b_count: %0d done pulses, required 4", ndone);
      end
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      op_a     = '0;
      op_b     = '0;
      luop     = '0;
      test_reset();
      test_all_ops();
      test_start_ignored();
      test_input_change();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
